// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first,
// through a single full-subtractor stage sequenced by an IDLE/RUN/DONE FSM.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, d_q, d_shift;
  logic [CW-1:0]    cnt_q;
  logic             br_q, zero_q;
  logic             diff, br_next, last_bit;

  // One full-subtractor stage working on the current LSBs.
  always_comb begin
    diff     = a_sr[0] ^ b_sr[0] ^ br_q;
    br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br_q);
    d_shift  = {diff, d_q[WIDTH-1:1]};
    last_bit = (cnt_q == LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath is reset too, because d/borrow/zero must read 0
  // during reset and a fresh start must not see stale operand bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      d_q    <= '0;
      br_q   <= 1'b0;
      zero_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br_q  <= bin;
            cnt_q <= '0;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br_q <= br_next;
          d_q  <= d_shift;
          // The counter holds on the final bit rather than wrapping.
          if (last_bit) begin
            zero_q <= (d_shift == '0);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign d      = d_q;
  assign borrow = br_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: directed WIDTH=8 scenarios plus an
// exhaustive WIDTH=4 sweep, with results matched through per-instance scoreboards.
module tb_serial_sub_ctrl;

  typedef struct {
    logic [31:0] d;
    logic        borrow;
    logic        zero;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, borrow8, zero8;
  logic [7:0] d8;

  logic       start4 = 1'b0, bin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, borrow4, zero4;
  logic [3:0] d4;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done4_cnt = 0;
  int   last_done4 = -1;
  exp_t q8[$];
  exp_t q4[$];

  serial_sub_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .d(d8), .borrow(borrow8), .zero(zero8)
  );

  serial_sub_ctrl #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .d(d4), .borrow(borrow4), .zero(zero4)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: plain integer subtraction reduced modulo 2^w.
  function automatic exp_t model(input int w, input int ta, input int tb, input int tbin);
    exp_t e;
    int   r;
    r        = ta - tb - tbin;
    e.d      = 32'(r & ((1 << w) - 1));
    e.borrow = (r < 0);
    e.zero   = (e.d == 0);
    return e;
  endfunction

  // Scoreboard side: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        check("w8_unexpected_done", 32'(done8), 32'(0));
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("w8_d", 32'(d8), e.d);
        check("w8_borrow", 32'(borrow8), 32'(e.borrow));
        check("w8_zero", 32'(zero8), 32'(e.zero));
      end
    end
    if (done4) begin
      done4_cnt++;
      if (last_done4 >= 0) check("w4_done_spacing", 32'(cyc - last_done4), 32'(6));
      last_done4 = cyc;
      if (q4.size() == 0) begin
        check("w4_unexpected_done", 32'(done4), 32'(0));
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("w4_d", 32'(d4), e.d);
        check("w4_borrow", 32'(borrow4), 32'(e.borrow));
        check("w4_zero", 32'(zero4), 32'(e.zero));
      end
    end
  end

  task automatic check_outputs_zero8(input string tag);
    check({tag, "_busy"}, 32'(busy8), 32'(0));
    check({tag, "_done"}, 32'(done8), 32'(0));
    check({tag, "_d"}, 32'(d8), 32'(0));
    check({tag, "_borrow"}, 32'(borrow8), 32'(0));
    check({tag, "_zero"}, 32'(zero8), 32'(0));
  endtask

  // One full WIDTH=8 operation with cycle-exact busy/done checks.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
    exp_t e;
    @(negedge clk);
    start8 = 1'b1; a8 = ta; b8 = tb; bin8 = tbin;
    e = model(8, int'(ta), int'(tb), int'(tbin));
    q8.push_back(e);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 1'b0;
      check("run8_busy", 32'(busy8), 32'(1));
      check("run8_done", 32'(done8), 32'(c == 9));
    end
    @(negedge clk);
    check("run8_idle_busy", 32'(busy8), 32'(0));
    check("run8_idle_done", 32'(done8), 32'(0));
    check("run8_hold_d", 32'(d8), e.d);
    check("run8_hold_borrow", 32'(borrow8), 32'(e.borrow));
    check("run8_hold_zero", 32'(zero8), 32'(e.zero));
  endtask

  initial begin
    exp_t e;

    // Reset state
    @(negedge clk);
    check_outputs_zero8("reset");
    check("reset_busy4", 32'(busy4), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero8("post_reset");

    // Directed results
    run8(8'h5A, 8'h3C, 1'b0);
    run8(8'h00, 8'h01, 1'b0);
    run8(8'h10, 8'h0F, 1'b1);
    run8(8'h77, 8'h77, 1'b1);
    run8(8'hFF, 8'h00, 1'b0);

    // Start while busy: the second request must be ignored
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hC3; b8 = 8'h21; bin8 = 1'b1;
    e = model(8, 'hC3, 'h21, 1);
    q8.push_back(e);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 1'b0;
      if (c == 3) begin start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; bin8 = 1'b0; end
      if (c == 4) start8 = 1'b0;
      check("busy_start_busy", 32'(busy8), 32'(1));
      check("busy_start_done", 32'(done8), 32'(c == 9));
    end
    for (int c = 10; c <= 15; c++) begin
      @(negedge clk);
      check("busy_start_idle_busy", 32'(busy8), 32'(0));
      check("busy_start_no_done", 32'(done8), 32'(0));
    end
    check("busy_start_d", 32'(d8), e.d);

    // Reset mid-run aborts the operation immediately
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 1'b0;
    end
    check("pre_abort_busy", 32'(busy8), 32'(1));
    #2 rst_n = 1'b0;
    #1 check_outputs_zero8("async_reset");
    void'(q8.pop_back());
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done8), 32'(0));
      check("abort_busy", 32'(busy8), 32'(0));
    end
    rst_n = 1'b1;
    run8(8'h5A, 8'h3C, 1'b0);

    // Exhaustive WIDTH=4 sweep with start held high
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      start4 = 1'b1;
      a4   = 4'(i >> 5);
      b4   = 4'(i >> 1);
      bin4 = i[0];
      q4.push_back(model(4, i >> 5, (i >> 1) & 15, i & 1));
      repeat (5) @(negedge clk);
    end
    @(negedge clk);
    start4 = 1'b0;
    for (int k = 0; k < 50 && q4.size() != 0; k++) @(negedge clk);
    repeat (8) @(negedge clk);
    check("w4_queue_drained", 32'(q4.size()), 32'(0));
    check("w4_done_count", 32'(done4_cnt), 32'(512));
    check("w8_queue_drained", 32'(q8.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
